bus_bank_arbiter: RTL
=====================

// Module: bus_bank_arbiter
// PURPOSE
// Round-robin arbiter sharing the bus register bank among NREQ requesters.
// The bank is the 1/4/8/32-bit A,B,C,D -> E,F,G,H capture registers.
// Arbiter grants one requester per transaction and registers its payload onto A..D.
// It pulses LOAD for one cycle; LOAD gates the bank's capture edge.
// Sits between the requesting agents and the bank, in the CLK domain.
// PARAMETERS
// NREQ        4   number of requesters, legal range 2..8
// GAP_CYCLES  1   idle cycles forced after each LOAD, legal range 0..15
// IDW         2   GNT_ID width, = clog2(NREQ)
// PORTS
// CLK     in   1        clock, all state updates on posedge
// RST     in   1        reset, asynchronous, active-high
// REQ     in   NREQ     request per requester; level, held until ACK seen
// A_IN    in   NREQ     1-bit payload, slice i belongs to requester i
// B_IN    in   4*NREQ   4-bit payload slices, [4i+3:4i]
// C_IN    in   8*NREQ   8-bit payload slices, [8i+7:8i]
// D_IN    in   32*NREQ  32-bit payload slices, [32i+31:32i]
// ACK     out  NREQ     one-hot, high for the single LOAD cycle of the winner
// LOAD    out  1        bank capture enable, one-cycle pulse
// A       out  1        granted payload to bank
// B       out  4        granted payload to bank
// C       out  8        granted payload to bank
// D       out  32       granted payload to bank
// GNT_ID  out  IDW     index of last winner, held between grants
// BUSY    out  1        high in LOAD and GAP states
// BEHAVIOUR
// - Reset: RST=1 forces state=IDLE, LOAD=0, ACK=0, A..D=0, GNT_ID=0, BUSY=0, PTR=NREQ-1.
//   These values take effect immediately (async), not at the next edge.
// - Reset mid-LOAD: the transaction is aborted, LOAD and ACK drop at once, no retry.
// - FSM states: IDLE, LOAD, GAP; all outputs registered.
// - IDLE: REQ is sampled only here.
//   If REQ!=0 at posedge, winner W = first set bit searching PTR+1, PTR+2, ... mod NREQ.
//   On that edge: A..D <= slice W, ACK <= onehot(W), LOAD <= 1, GNT_ID <= W, PTR <= W, state <= LOAD.
//   If REQ==0, stay in IDLE with all outputs held.
// - LOAD: lasts exactly 1 cycle. Next edge: LOAD <= 0, ACK <= 0.
//   Then state <= GAP if GAP_CYCLES>0, else IDLE.
// - GAP: counts GAP_CYCLES cycles, then IDLE. REQ is ignored in GAP.
// - Latency: REQ high in IDLE -> LOAD/ACK high 1 cycle later.
//   Max throughput: one load per 2+GAP_CYCLES cycles.
// - Requester handshake: drop REQ, or present the next payload, at the edge where ACK=1 is sampled.
//   REQ still high when IDLE resamples counts as a new request.
// - Payload is captured at the grant edge. Slice changes after that edge do not affect A..D.
// - A..D hold the last granted payload until the next grant, never 'x' after reset.
// - Fairness: a requester held high is served within NREQ grants.
// - PTR wraps NREQ-1 -> 0.
// - Out-of-range NREQ/GAP_CYCLES is a static configuration error: elaboration $error.
// TESTING
// 1 RST=1 with REQ=1111 -> LOAD=0, ACK=0000, A..D=0, GNT_ID=0, BUSY=0 while reset is held.
// 2 REQ=0010, D_IN[63:32]=32'hDEADBEEF, C slice1=8'hA5 -> next cycle LOAD=1, ACK=0010, D=DEADBEEF, C=A5, GNT_ID=1; LOAD=0 the cycle after.
// 3 REQ=1111 re-asserted continuously, GAP_CYCLES=1 -> GNT_ID sequence 0,1,2,3,0; LOAD high every 3rd cycle.
// 4 GAP_CYCLES=0, REQ=1111 -> LOAD alternates 1,0,1,0; BUSY=1 only in LOAD cycles.
// 5 Last winner 0, then REQ=1001 -> grant 3 (not 0); then REQ=1001 again -> grant 0.
// 6 RST pulsed mid-cycle during LOAD -> LOAD/ACK fall before the next edge; after release, REQ=1111 -> grant 0.

Source files
------------

// File: rtl/bus_bank_arbiter.sv
// rtl/bus_bank_arbiter.sv - round-robin arbiter loading one requester's payload into the bus register bank
module bus_bank_arbiter #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 1,
  parameter int IDW        = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      a_in_i,
  input  logic [4*NREQ-1:0]    b_in_i,
  input  logic [8*NREQ-1:0]    c_in_i,
  input  logic [32*NREQ-1:0]   d_in_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 load_o,
  output logic                 a_o,
  output logic [3:0]           b_o,
  output logic [7:0]           c_o,
  output logic [31:0]          d_o,
  output logic [IDW-1:0]       gnt_id_o,
  output logic                 busy_o
);

  // Static configuration checks.
  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("bus_bank_arbiter: NREQ must be in 2..8");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("bus_bank_arbiter: GAP_CYCLES must be in 0..15");
    end
    if (IDW != $clog2(NREQ)) begin : g_bad_idw
      $error("bus_bank_arbiter: IDW must equal clog2(NREQ)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            load_q, load_d;
  logic            a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [7:0]      c_q, c_d;
  logic [31:0]     d_q, d_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW:0]    cand;
  logic            a_sel;
  logic [3:0]      b_sel;
  logic [7:0]      c_sel;
  logic [31:0]     d_sel;

  // Round-robin search: first requester after the last winner, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && req_i[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  // Select the candidate winner's payload slices.
  always_comb begin
    a_sel = 1'b0;
    b_sel = '0;
    c_sel = '0;
    d_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win == IDW'(j)) begin
        a_sel = a_in_i[j];
        b_sel = b_in_i[4*j +: 4];
        c_sel = c_in_i[8*j +: 8];
        d_sel = d_in_i[32*j +: 32];
      end
    end
  end

  // Next-state and registered-output logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    ack_d     = '0;
    load_d    = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        // Requests are only looked at here; the payload is frozen at this edge.
        if (found) begin
          state_d = S_LOAD;
          ack_d   = NREQ'(1) << win;
          load_d  = 1'b1;
          a_d     = a_sel;
          b_d     = b_sel;
          c_d     = c_sel;
          d_d     = d_sel;
          gnt_d   = win;
          ptr_d   = win;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (GAP_CYCLES > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LAST;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_RST;
      gap_cnt_q <= '0;
      ack_q     <= '0;
      load_q    <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      ack_q     <= ack_d;
      load_q    <= load_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  assign ack_o    = ack_q;
  assign load_o   = load_q;
  assign a_o      = a_q;
  assign b_o      = b_q;
  assign c_o      = c_q;
  assign d_o      = d_q;
  assign gnt_id_o = gnt_q;
  assign busy_o   = busy_q;

endmodule
